// File: rtl/dmem_resp_pkg.sv
// Shared constants, types and helpers for the data-memory response block.
// Holds the reset/enable/flag encodings and the LL/SC reservation state encoding.
package dmem_resp_pkg;

  localparam logic        RstEnable  = 1'b0;
  localparam logic        RamWrite   = 1'b1;
  localparam logic        RamUnWrite = 1'b0;
  localparam logic        RamEnable  = 1'b1;
  localparam logic        RamDisable = 1'b0;
  localparam logic        SetFlag    = 1'b1;
  localparam logic        ClearFlag  = 1'b0;
  localparam logic        Valid      = 1'b1;
  localparam logic        Invalid    = 1'b0;
  localparam logic [31:0] Zero       = 32'h0000_0000;

  typedef enum logic {
    LlIdle     = 1'b0,
    LlReserved = 1'b1
  } ll_state_e;

  // Word accesses only: any nonzero byte offset is an alignment error.
  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/llbit_ctrl.sv
// LL/SC reservation tracker.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   wbit, wLLbit  LLbit write request and value (set on LL, clear on SC)
//   excpt         exception/eret commit, kills the reservation
//   rdAcc, wrAcc  accepted (aligned, enabled, out of reset) read / write this cycle
//   idx           word index of the current access
//   rLLbit        reservation valid
//   resIdx        reserved word index
module llbit_ctrl
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wbit,
  input  logic                  wLLbit,
  input  logic                  excpt,
  input  logic                  rdAcc,
  input  logic                  wrAcc,
  input  logic [DEPTH_LOG2-1:0] idx,
  output logic                  rLLbit,
  output logic [DEPTH_LOG2-1:0] resIdx
);

  ll_state_e             state_q, state_d;
  logic [DEPTH_LOG2-1:0] res_idx_q, res_idx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LlIdle;
      res_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      res_idx_q <= res_idx_d;
    end
  end

  // Priority: exception, then explicit LLbit update, then store snoop.
  always_comb begin
    state_d   = state_q;
    res_idx_d = res_idx_q;
    if (excpt) begin
      state_d = LlIdle;
    end else if (wbit == Valid) begin
      if (wLLbit == SetFlag) begin
        // An LL that is not an accepted read leaves everything untouched.
        if (rdAcc) begin
          state_d   = LlReserved;
          res_idx_d = idx;
        end
      end else begin
        state_d = LlIdle;
      end
    end else if (wbit == Invalid && wrAcc && state_q == LlReserved && idx == res_idx_q) begin
      state_d = LlIdle;
    end
  end

  assign rLLbit = (state_q == LlReserved);
  assign resIdx = res_idx_q;

endmodule

// File: rtl/dmem_resp.sv
// Word-addressed data memory with LL/SC reservation tracking.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   memCe, memWr    access enable, write strobe (read when low)
//   memAddr         byte address; word index is memAddr[DEPTH_LOG2+1:2], upper bits ignored
//   wtData, rdData  store data, combinational load data (zero when no accepted read)
//   wbit, wLLbit    LLbit write request / value
//   excpt           exception/eret commit, kills reservation
//   rLLbit          reservation valid
//   addrErr         combinational misaligned-access flag
//   rdCnt, wrCnt, scFailCnt  saturating statistics, present only with DMEM_STATS_EN
// Optional feature macro: DMEM_STATS_EN.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memCe,
  input  logic        memWr,
  input  logic [31:0] memAddr,
  input  logic [31:0] wtData,
  output logic [31:0] rdData,
  input  logic        wbit,
  input  logic        wLLbit,
  input  logic        excpt,
  output logic        rLLbit,
`ifdef DMEM_STATS_EN
  output logic [15:0] rdCnt,
  output logic [15:0] wrCnt,
  output logic [15:0] scFailCnt,
`endif
  output logic        addrErr
);

  localparam int unsigned Words = 2 ** DEPTH_LOG2;

  logic [31:0]           mem [Words];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DEPTH_LOG2-1:0] unused_res_idx;
  logic                  unused_addr_hi;

  assign idx            = memAddr[DEPTH_LOG2+1:2];
  assign unused_addr_hi = ^memAddr[31:DEPTH_LOG2+2];

  assign addrErr = (memCe == RamEnable) && misaligned(memAddr[1:0]);

  // Both access kinds are blocked while reset is held, which also aborts a write
  // whose edge arrives during reset.
  assign rd_acc = (rst != RstEnable) && (memCe == RamEnable) && (memWr == RamUnWrite)
                  && !addrErr;
  assign wr_acc = (rst != RstEnable) && (memCe != RamDisable) && (memWr == RamWrite)
                  && !addrErr;

  // Read is combinational from the pre-edge array, so a same-cycle write is not seen.
  assign rdData = rd_acc ? mem[idx] : Zero;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[idx] <= wtData;
    end
  end

  llbit_ctrl #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_llbit_ctrl (
    .clk    (clk),
    .rst    (rst),
    .wbit   (wbit),
    .wLLbit (wLLbit),
    .excpt  (excpt),
    .rdAcc  (rd_acc),
    .wrAcc  (wr_acc),
    .idx    (idx),
    .rLLbit (rLLbit),
    .resIdx (unused_res_idx)
  );

`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, sc_fail_cnt_q;
  logic        sc_fail;

  // An SC attempted with no live reservation.
  assign sc_fail = (wbit == Valid) && (wLLbit == ClearFlag) && !rLLbit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      sc_fail_cnt_q <= '0;
    end else begin
      if (rd_acc && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (wr_acc && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (sc_fail && sc_fail_cnt_q != 16'hFFFF) sc_fail_cnt_q <= sc_fail_cnt_q + 16'd1;
    end
  end

  assign rdCnt     = rd_cnt_q;
  assign wrCnt     = wr_cnt_q;
  assign scFailCnt = sc_fail_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed spec scenarios plus randomized traffic
// compared against a behavioural memory/reservation model.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memCe = 1'b0;
  logic        memWr = 1'b0;
  logic [31:0] memAddr = '0;
  logic [31:0] wtData = '0;
  logic        wbit = 1'b0;
  logic        wLLbit = 1'b0;
  logic        excpt = 1'b0;
  logic [31:0] rdData;
  logic        rLLbit;
  logic        addrErr;
`ifdef DMEM_STATS_EN
  logic [15:0] rdCnt, wrCnt, scFailCnt;
`endif

  dmem_resp #(
    .DEPTH_LOG2(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .memCe    (memCe),
    .memWr    (memWr),
    .memAddr  (memAddr),
    .wtData   (wtData),
    .rdData   (rdData),
    .wbit     (wbit),
    .wLLbit   (wLLbit),
    .excpt    (excpt),
    .rLLbit   (rLLbit),
`ifdef DMEM_STATS_EN
    .rdCnt    (rdCnt),
    .wrCnt    (wrCnt),
    .scFailCnt(scFailCnt),
`endif
    .addrErr  (addrErr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model
  logic [31:0] m [1024];
  bit          res_v = 1'b0;
  int          res_w = 0;
  int          c_rd = 0, c_wr = 0, c_sc = 0;

  function automatic bit acc_ok();
    return memCe && memAddr[1:0] == 2'b00;
  endfunction

  function automatic logic [31:0] exp_rd();
    return (acc_ok() && !memWr) ? m[memAddr[11:2]] : 32'h0;
  endfunction

  function automatic bit exp_err();
    return memCe && memAddr[1:0] != 2'b00;
  endfunction

  task automatic model_reset();
    res_v = 1'b0;
    res_w = 0;
    c_rd  = 0;
    c_wr  = 0;
    c_sc  = 0;
  endtask

  // Applies the effect of one rising edge with the inputs currently driven.
  task automatic model_edge();
    int  w;
    bit  rd, wr, was_v;
    w     = int'(memAddr[11:2]);
    rd    = acc_ok() && !memWr;
    wr    = acc_ok() && memWr;
    was_v = res_v;
    if (rd) c_rd++;
    if (wr) c_wr++;
    if (wbit && !wLLbit && !was_v) c_sc++;
    if (excpt) res_v = 1'b0;
    else if (wbit) begin
      if (wLLbit) begin
        if (rd) begin
          res_v = 1'b1;
          res_w = w;
        end
      end else res_v = 1'b0;
    end else if (wr && was_v && w == res_w) res_v = 1'b0;
    if (wr) m[w] = wtData;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit ce, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input bit wb, input bit wl, input bit ex);
    memCe   = ce;
    memWr   = wr;
    memAddr = a;
    wtData  = d;
    wbit    = wb;
    wLLbit  = wl;
    excpt   = ex;
  endtask

  task automatic test_reset();
    drive(1, 0, 32'h10, 32'h0, 0, 0, 0);
    #3;
    n_checks++;
    if (rdData !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rddata: got %h want %h", rdData, 32'h0);
    end
    n_checks++;
    if (rLLbit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rllbit: got %b want 0", rLLbit);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 32'h0, 32'h0, 0, 0, 0);
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 1024; i++) begin
      drive(1, 1, i * 4, $urandom, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_directed();
    logic [31:0] prior;
    prior = m[4];
    drive(1, 0, 32'h10, 32'h0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (rdData !== prior) begin
      n_fail++;
      $display("FAIL rd_prior: got %h want %h", rdData, prior);
    end
    tick();
    drive(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (rdData !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_during_write: got %h want 0", rdData);
    end
    tick();
    drive(1, 0, 32'h10, 32'h0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (rdData !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rd_after_write: got %h want deadbeef", rdData);
    end
    tick();
    // Misaligned store must flag and be suppressed
    drive(1, 1, 32'h13, 32'h1234_5678, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (addrErr !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_err: got %b want 1", addrErr);
    end
    n_checks++;
    if (rdData !== 32'h0) begin
      n_fail++;
      $display("FAIL misalign_rd: got %h want 0", rdData);
    end
    tick();
    drive(1, 0, 32'h10, 32'h0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (rdData !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL misalign_suppress: got %h want deadbeef", rdData);
    end
    n_checks++;
    if (addrErr !== 1'b0) begin
      n_fail++;
      $display("FAIL aligned_err: got %b want 0", addrErr);
    end
    tick();
    // Index wrap
    drive(1, 1, 32'h1000, 32'h0BAD_F00D, 0, 0, 0);
    tick();
    drive(1, 0, 32'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (rdData !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL wrap: got %h want 0badf00d", rdData);
    end
    tick();
  endtask

  task automatic test_llsc();
    drive(1, 0, 32'h20, 32'h0, 1, 1, 0);
    tick();
    n_checks++;
    if (rLLbit !== 1'b1) begin
      n_fail++;
      $display("FAIL ll_set: got %b want 1", rLLbit);
    end
    drive(1, 1, 32'h24, 32'h5, 0, 0, 0);
    tick();
    n_checks++;
    if (rLLbit !== 1'b1) begin
      n_fail++;
      $display("FAIL snoop_other: got %b want 1", rLLbit);
    end
    drive(1, 1, 32'h20, 32'h6, 0, 0, 0);
    tick();
    n_checks++;
    if (rLLbit !== 1'b0) begin
      n_fail++;
      $display("FAIL snoop_hit: got %b want 0", rLLbit);
    end
    drive(1, 0, 32'h20, 32'h0, 1, 1, 1);
    tick();
    n_checks++;
    if (rLLbit !== 1'b0) begin
      n_fail++;
      $display("FAIL ll_excpt: got %b want 0", rLLbit);
    end
    // Misaligned LL leaves an idle tracker idle
    drive(1, 0, 32'h22, 32'h0, 1, 1, 0);
    tick();
    n_checks++;
    if (rLLbit !== 1'b0) begin
      n_fail++;
      $display("FAIL ll_misalign_idle: got %b want 0", rLLbit);
    end
    // Re-arm on a new word, then a store to the old word must not clear it
    drive(1, 0, 32'h20, 32'h0, 1, 1, 0);
    tick();
    drive(1, 0, 32'h30, 32'h0, 1, 1, 0);
    tick();
    drive(1, 1, 32'h20, 32'h7, 0, 0, 0);
    tick();
    n_checks++;
    if (rLLbit !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm: got %b want 1", rLLbit);
    end
    // LL as a write leaves state unchanged even on the reserved word
    drive(1, 1, 32'h30, 32'h8, 1, 1, 0);
    tick();
    n_checks++;
    if (rLLbit !== 1'b1) begin
      n_fail++;
      $display("FAIL ll_write_hold: got %b want 1", rLLbit);
    end
    drive(0, 0, 32'h0, 32'h0, 1, 0, 0);
    tick();
    n_checks++;
    if (rLLbit !== 1'b0) begin
      n_fail++;
      $display("FAIL sc_clear: got %b want 0", rLLbit);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  lo;
    int          w;
    for (int i = 0; i < 600; i++) begin
      w  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 7));
      lo = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      a  = ($urandom & 32'hFFFF_F000) | (w << 2) | 32'(lo);
      drive($urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1, a, $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
      @(negedge clk);
      n_checks++;
      if (addrErr !== exp_err()) begin
        n_fail++;
        $display("FAIL rand_adderr[%0d]: got %b want %b", i, addrErr, exp_err());
      end
      n_checks++;
      if (rdData !== exp_rd()) begin
        n_fail++;
        $display("FAIL rand_rddata[%0d]: got %h want %h", i, rdData, exp_rd());
      end
      tick();
      n_checks++;
      if (rLLbit !== res_v) begin
        n_fail++;
        $display("FAIL rand_rllbit[%0d]: got %b want %b", i, rLLbit, res_v);
      end
    end
`ifdef DMEM_STATS_EN
    n_checks++;
    if (rdCnt !== 16'(c_rd) || wrCnt !== 16'(c_wr) || scFailCnt !== 16'(c_sc)) begin
      n_fail++;
      $display("FAIL rand_stats: got %0d/%0d/%0d want %0d/%0d/%0d",
               rdCnt, wrCnt, scFailCnt, c_rd, c_wr, c_sc);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] old;
    drive(1, 0, 32'h40, 32'h0, 1, 1, 0);
    tick();
    old = m[16];
    drive(1, 1, 32'h40, 32'h1234_5678, 0, 0, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (rLLbit !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst_rllbit: got %b want 0", rLLbit);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 32'h40, 32'h0, 0, 0, 0);
    #1;
    n_checks++;
    if (rdData !== old) begin
      n_fail++;
      $display("FAIL rst_abort_write: got %h want %h", rdData, old);
    end
    tick();
  endtask

`ifdef DMEM_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'(i * 4), 32'h0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 32'(32'h80 + i * 4), $urandom, 0, 0, 0);
      tick();
    end
    drive(0, 0, 32'h0, 32'h0, 1, 0, 0);
    tick();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 0);
    n_checks++;
    if (rdCnt !== 16'd3 || wrCnt !== 16'd2 || scFailCnt !== 16'd1) begin
      n_fail++;
      $display("FAIL stats_count: got %0d/%0d/%0d want 3/2/1", rdCnt, wrCnt, scFailCnt);
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (rdCnt !== 16'd0 || wrCnt !== 16'd0 || scFailCnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_rst: got %0d/%0d/%0d want 0/0/0", rdCnt, wrCnt, scFailCnt);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_directed();
    test_llsc();
    test_random();
    test_reset_mid();
`ifdef DMEM_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
